// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: registered decode fields behind a valid/ready
// handshake, with an optional 2-entry skid buffer for full throughput under backpressure.
module decode_stage #(
   parameter int PC_WIDTH   = 32,
   parameter bit SKID_EN    = 1'b1,
   parameter bit ZERO_RD_WE = 1'b1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         instr_raw,
   input  logic [PC_WIDTH-1:0] in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PC_WIDTH-1:0] out_pc,
   output logic [4:0]          rs1,
   output logic [4:0]          rs2,
   output logic [4:0]          rd,
   output logic [3:0]          alu_op,
   output logic                alu_src,
   output logic [31:0]         imm,
   output logic                branch,
   output logic [2:0]          funct3,
   output logic                jal,
   output logic                jalr,
   output logic                lui,
   output logic                auipc,
   output logic                mem_read,
   output logic                mem_write,
   output logic [1:0]          mem_size,
   output logic                mem_unsigned,
   output logic                reg_write,
   output logic                illegal
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_NONE = 4'd15;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic [PC_WIDTH-1:0] pc;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [3:0]          alu_op;
      logic                alu_src;
      logic [31:0]         imm;
      logic                branch;
      logic [2:0]          funct3;
      logic                jal;
      logic                jalr;
      logic                lui;
      logic                auipc;
      logic                mem_read;
      logic                mem_write;
      logic [1:0]          mem_size;
      logic                mem_unsigned;
      logic                reg_write;
      logic                illegal;
   } dec_t;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = instr_raw[6:0];
   assign f3     = instr_raw[14:12];
   assign f7     = instr_raw[31:25];
   assign imm_i  = {{20{instr_raw[31]}}, instr_raw[31:20]};
   assign imm_s  = {{20{instr_raw[31]}}, instr_raw[31:25], instr_raw[11:7]};
   assign imm_b  = {{19{instr_raw[31]}}, instr_raw[31], instr_raw[7],
                    instr_raw[30:25], instr_raw[11:8], 1'b0};
   assign imm_u  = {instr_raw[31:12], 12'b0};
   assign imm_j  = {{11{instr_raw[31]}}, instr_raw[31], instr_raw[19:12],
                    instr_raw[20], instr_raw[30:21], 1'b0};

   dec_t dec_next;
   logic legal;
   logic writes_rd;

   always_comb begin
      dec_next        = '0;
      dec_next.pc     = in_pc;
      dec_next.rs1    = instr_raw[19:15];
      dec_next.rs2    = instr_raw[24:20];
      dec_next.rd     = instr_raw[11:7];
      dec_next.funct3 = f3;
      dec_next.alu_op = ALU_ADD;
      legal           = 1'b1;
      writes_rd       = 1'b0;
      case (opcode)
         OPC_LOAD: begin
            dec_next.imm          = imm_i;
            dec_next.alu_src      = 1'b1;
            dec_next.mem_read     = 1'b1;
            dec_next.mem_size     = f3[1:0];
            dec_next.mem_unsigned = f3[2];
            writes_rd             = 1'b1;
            legal                 = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
         end
         OPC_STORE: begin
            dec_next.imm       = imm_s;
            dec_next.alu_src   = 1'b1;
            dec_next.mem_write = 1'b1;
            dec_next.mem_size  = f3[1:0];
            legal              = (f3 <= 3'd2);
         end
         OPC_OP: begin
            writes_rd = 1'b1;
            case ({f7, f3})
               10'b0000000_000: dec_next.alu_op = ALU_ADD;
               10'b0100000_000: dec_next.alu_op = ALU_SUB;
               10'b0000000_001: dec_next.alu_op = ALU_SLL;
               10'b0000000_010: dec_next.alu_op = ALU_SLT;
               10'b0000000_011: dec_next.alu_op = ALU_SLTU;
               10'b0000000_100: dec_next.alu_op = ALU_XOR;
               10'b0000000_101: dec_next.alu_op = ALU_SRL;
               10'b0100000_101: dec_next.alu_op = ALU_SRA;
               10'b0000000_110: dec_next.alu_op = ALU_OR;
               10'b0000000_111: dec_next.alu_op = ALU_AND;
               default:         legal = 1'b0;
            endcase
         end
         OPC_OP_IMM: begin
            dec_next.imm     = imm_i;
            dec_next.alu_src = 1'b1;
            writes_rd        = 1'b1;
            case (f3)
               3'd0: dec_next.alu_op = ALU_ADD;
               3'd2: dec_next.alu_op = ALU_SLT;
               3'd3: dec_next.alu_op = ALU_SLTU;
               3'd4: dec_next.alu_op = ALU_XOR;
               3'd6: dec_next.alu_op = ALU_OR;
               3'd7: dec_next.alu_op = ALU_AND;
               3'd1: begin
                  dec_next.alu_op = ALU_SLL;
                  legal           = (f7 == 7'b0000000);
               end
               default: begin
                  // funct7 bit 5 picks arithmetic vs logical right shift
                  dec_next.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                  legal           = (f7 == 7'b0000000) || (f7 == 7'b0100000);
               end
            endcase
         end
         OPC_BRANCH: begin
            dec_next.imm    = imm_b;
            dec_next.alu_op = ALU_SUB;
            dec_next.branch = 1'b1;
            legal           = (f3 != 3'd2) && (f3 != 3'd3);
         end
         OPC_JAL: begin
            dec_next.imm = imm_j;
            dec_next.jal = 1'b1;
            writes_rd    = 1'b1;
         end
         OPC_JALR: begin
            dec_next.imm     = imm_i;
            dec_next.alu_src = 1'b1;
            dec_next.jalr    = 1'b1;
            writes_rd        = 1'b1;
            legal            = (f3 == 3'd0);
         end
         OPC_LUI: begin
            dec_next.imm     = imm_u;
            dec_next.alu_src = 1'b1;
            dec_next.lui     = 1'b1;
            writes_rd        = 1'b1;
         end
         OPC_AUIPC: begin
            dec_next.imm     = imm_u;
            dec_next.alu_src = 1'b1;
            dec_next.auipc   = 1'b1;
            writes_rd        = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      // Illegal words keep only the raw register/funct3 fields and pc
      if (!legal) begin
         dec_next.alu_op       = ALU_NONE;
         dec_next.alu_src      = 1'b0;
         dec_next.imm          = '0;
         dec_next.branch       = 1'b0;
         dec_next.jal          = 1'b0;
         dec_next.jalr         = 1'b0;
         dec_next.lui          = 1'b0;
         dec_next.auipc        = 1'b0;
         dec_next.mem_read     = 1'b0;
         dec_next.mem_write    = 1'b0;
         dec_next.mem_size     = 2'd0;
         dec_next.mem_unsigned = 1'b0;
         dec_next.illegal      = 1'b1;
      end
      dec_next.reg_write = writes_rd && legal && (!ZERO_RD_WE || (instr_raw[11:7] != 5'd0));
   end

   dec_t out_reg, skid_reg;
   logic out_valid_reg, skid_valid_reg;
   logic accept, retire;

   generate
      if (SKID_EN) begin : g_skid_ready
         assign in_ready = !skid_valid_reg;
      end else begin : g_single_ready
         assign in_ready = !out_valid_reg || out_ready;
      end
   endgenerate

   assign accept = in_valid && in_ready;
   assign retire = out_valid_reg && out_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_reg  <= 1'b0;
         skid_valid_reg <= 1'b0;
         out_reg        <= '0;
         skid_reg       <= '0;
      end else if (flush) begin
         out_valid_reg  <= 1'b0;
         skid_valid_reg <= 1'b0;
      end else if (!out_valid_reg || retire) begin
         // Output slot frees up: older skid word first, else the new word
         if (skid_valid_reg) begin
            out_reg        <= skid_reg;
            out_valid_reg  <= 1'b1;
            skid_valid_reg <= 1'b0;
         end else if (accept) begin
            out_reg       <= dec_next;
            out_valid_reg <= 1'b1;
         end else begin
            out_valid_reg <= 1'b0;
         end
      end else if (accept && SKID_EN) begin
         skid_reg       <= dec_next;
         skid_valid_reg <= 1'b1;
      end
   end

   assign out_valid    = out_valid_reg;
   assign out_pc       = out_reg.pc;
   assign rs1          = out_reg.rs1;
   assign rs2          = out_reg.rs2;
   assign rd           = out_reg.rd;
   assign alu_op       = out_reg.alu_op;
   assign alu_src      = out_reg.alu_src;
   assign imm          = out_reg.imm;
   assign branch       = out_reg.branch;
   assign funct3       = out_reg.funct3;
   assign jal          = out_reg.jal;
   assign jalr         = out_reg.jalr;
   assign lui          = out_reg.lui;
   assign auipc        = out_reg.auipc;
   assign mem_read     = out_reg.mem_read;
   assign mem_write    = out_reg.mem_write;
   assign mem_size     = out_reg.mem_size;
   assign mem_unsigned = out_reg.mem_unsigned;
   assign reg_write    = out_reg.reg_write;
   assign illegal      = out_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of hand-decoded RV32I words plus
// backpressure, flush and mid-stream reset sequences.
module tb_decode_stage;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_NONE = 4'd15;

   // flag bits: branch jal jalr lui auipc mem_read mem_write reg_write illegal
   localparam logic [8:0] F_BR    = 9'h100;
   localparam logic [8:0] F_JAL   = 9'h080;
   localparam logic [8:0] F_JALR  = 9'h040;
   localparam logic [8:0] F_LUI   = 9'h020;
   localparam logic [8:0] F_AUIPC = 9'h010;
   localparam logic [8:0] F_MR    = 9'h008;
   localparam logic [8:0] F_MW    = 9'h004;
   localparam logic [8:0] F_RW    = 9'h002;
   localparam logic [8:0] F_ILL   = 9'h001;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        alu_src;
      logic [31:0] imm;
      logic        branch;
      logic [2:0]  funct3;
      logic        jal;
      logic        jalr;
      logic        lui;
      logic        auipc;
      logic        mem_read;
      logic        mem_write;
      logic [1:0]  mem_size;
      logic        mem_unsigned;
      logic        reg_write;
      logic        illegal;
   } dec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      dec_t        exp;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr_raw = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [4:0]  rs1, rs2, rd;
   logic [3:0]  alu_op;
   logic        alu_src;
   logic [31:0] imm;
   logic        branch;
   logic [2:0]  funct3;
   logic        jal, jalr, lui, auipc, mem_read, mem_write;
   logic [1:0]  mem_size;
   logic        mem_unsigned, reg_write, illegal;

   int n_cmp = 0;
   int n_fail = 0;
   vec_t vt[20];
   dec_t act;

   always #5 clock = ~clock;

   decode_stage #(.PC_WIDTH(32), .SKID_EN(1'b1), .ZERO_RD_WE(1'b1)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .instr_raw(instr_raw), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op), .alu_src(alu_src), .imm(imm),
      .branch(branch), .funct3(funct3), .jal(jal), .jalr(jalr), .lui(lui), .auipc(auipc),
      .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
      .mem_unsigned(mem_unsigned), .reg_write(reg_write), .illegal(illegal)
   );

   assign act = {rs1, rs2, rd, alu_op, alu_src, imm, branch, funct3, jal, jalr, lui, auipc,
                 mem_read, mem_write, mem_size, mem_unsigned, reg_write, illegal};

   function automatic dec_t mk(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                               input logic [3:0] alu, input logic src, input logic [31:0] im,
                               input logic [2:0] f3, input logic [8:0] fl,
                               input logic [1:0] sz, input logic uns);
      dec_t e;
      e = '{rs1: r1, rs2: r2, rd: d, alu_op: alu, alu_src: src, imm: im,
            branch: fl[8], funct3: f3, jal: fl[7], jalr: fl[6], lui: fl[5], auipc: fl[4],
            mem_read: fl[3], mem_write: fl[2], mem_size: sz, mem_unsigned: uns,
            reg_write: fl[1], illegal: fl[0]};
      return e;
   endfunction

   // addi x<k>, x0, k : tags a word by its rd field
   function automatic logic [31:0] tag_word(input int k);
      logic [31:0] w;
      w = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
      return w;
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end else begin
         $display("ok   %s: %0h", name, got);
      end
   endtask

   task automatic send(input logic [31:0] w);
      @(negedge clock);
      in_valid  = 1'b1;
      instr_raw = w;
      in_pc     = 32'h2000 + w;
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vt[0]  = '{32'h00500093, 32'h1000, mk(0, 5, 1, ALU_ADD, 1, 32'd5, 0, F_RW, 0, 0)};
      vt[1]  = '{32'hFE20AE23, 32'h1004, mk(1, 2, 28, ALU_ADD, 1, 32'hFFFFFFFC, 2, F_MW, 2, 0)};
      vt[2]  = '{32'h008000EF, 32'h0100, mk(0, 8, 1, ALU_ADD, 0, 32'd8, 0, F_JAL | F_RW, 0, 0)};
      vt[3]  = '{32'hFFFFFFFF, 32'h1008, mk(31, 31, 31, ALU_NONE, 0, 32'd0, 7, F_ILL, 0, 0)};
      vt[4]  = '{32'h002081B3, 32'h100C, mk(1, 2, 3, ALU_ADD, 0, 32'd0, 0, F_RW, 0, 0)};
      vt[5]  = '{32'h402081B3, 32'h1010, mk(1, 2, 3, ALU_SUB, 0, 32'd0, 0, F_RW, 0, 0)};
      vt[6]  = '{32'h4020D1B3, 32'h1014, mk(1, 2, 3, ALU_SRA, 0, 32'd0, 5, F_RW, 0, 0)};
      vt[7]  = '{32'h0020B1B3, 32'h1018, mk(1, 2, 3, ALU_SLTU, 0, 32'd0, 3, F_RW, 0, 0)};
      vt[8]  = '{32'h402091B3, 32'h101C, mk(1, 2, 3, ALU_NONE, 0, 32'd0, 1, F_ILL, 0, 0)};
      vt[9]  = '{32'h00812283, 32'h1020, mk(2, 8, 5, ALU_ADD, 1, 32'd8, 2, F_MR | F_RW, 2, 0)};
      vt[10] = '{32'hFFF14283, 32'h1024, mk(2, 31, 5, ALU_ADD, 1, 32'hFFFFFFFF, 4, F_MR | F_RW, 0, 1)};
      vt[11] = '{32'h00813283, 32'h1028, mk(2, 8, 5, ALU_NONE, 0, 32'd0, 3, F_ILL, 0, 0)};
      vt[12] = '{32'hFE208CE3, 32'h102C, mk(1, 2, 25, ALU_SUB, 0, 32'hFFFFFFF8, 0, F_BR, 0, 0)};
      vt[13] = '{32'hFE20ACE3, 32'h1030, mk(1, 2, 25, ALU_NONE, 0, 32'd0, 2, F_ILL, 0, 0)};
      vt[14] = '{32'h004280E7, 32'h1034, mk(5, 4, 1, ALU_ADD, 1, 32'd4, 0, F_JALR | F_RW, 0, 0)};
      vt[15] = '{32'h123453B7, 32'h1038, mk(8, 3, 7, ALU_ADD, 1, 32'h12345000, 5, F_LUI | F_RW, 0, 0)};
      vt[16] = '{32'h00001017, 32'h103C, mk(0, 0, 0, ALU_ADD, 1, 32'h00001000, 1, F_AUIPC, 0, 0)};
      vt[17] = '{32'h40325213, 32'h1040, mk(4, 3, 4, ALU_SRA, 1, 32'h00000403, 5, F_RW, 0, 0)};
      vt[18] = '{32'h40321213, 32'h1044, mk(4, 3, 4, ALU_NONE, 0, 32'd0, 1, F_ILL, 0, 0)};
      vt[19] = '{32'h00000013, 32'h1048, mk(0, 0, 0, ALU_ADD, 1, 32'd0, 0, 9'h000, 0, 0)};

      repeat (2) @(posedge clock);
      #1;
      chk("reset out_valid", 128'(out_valid), 128'(0));
      chk("reset in_ready", 128'(in_ready), 128'(1));
      chk("reset payload", 128'(act), 128'(0));
      chk("reset out_pc", 128'(out_pc), 128'(0));
      @(negedge clock);
      reset     = 1'b0;
      out_ready = 1'b1;

      // back-to-back stream at full throughput
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         in_valid  = 1'b1;
         instr_raw = vt[i].instr;
         in_pc     = vt[i].pc;
         tick();
         chk($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'(1));
         chk($sformatf("vec%0d in_ready", i), 128'(in_ready), 128'(1));
         chk($sformatf("vec%0d payload %08h", i, vt[i].instr), 128'(act), 128'(vt[i].exp));
         chk($sformatf("vec%0d out_pc", i), 128'(out_pc), 128'(vt[i].pc));
      end
      @(negedge clock);
      in_valid = 1'b0;
      tick();
      chk("drain out_valid", 128'(out_valid), 128'(0));

      // backpressure: three words against a stalled consumer
      @(negedge clock);
      out_ready = 1'b0;
      send(tag_word(1));
      tick();
      chk("bp w1 captured rd", 128'(rd), 128'(1));
      chk("bp in_ready after w1", 128'(in_ready), 128'(1));
      send(tag_word(2));
      tick();
      chk("bp held rd", 128'(rd), 128'(1));
      chk("bp in_ready skid full", 128'(in_ready), 128'(0));
      send(tag_word(3));
      tick();
      chk("bp w3 refused rd", 128'(rd), 128'(1));
      chk("bp in_ready still 0", 128'(in_ready), 128'(0));
      @(negedge clock);
      out_ready = 1'b1;
      tick();
      chk("bp release rd", 128'(rd), 128'(2));
      chk("bp release out_pc", 128'(out_pc), 128'(32'h2000 + tag_word(2)));
      chk("bp in_ready reopened", 128'(in_ready), 128'(1));
      tick();
      chk("bp w3 passthrough rd", 128'(rd), 128'(3));
      chk("bp w3 out_valid", 128'(out_valid), 128'(1));
      @(negedge clock);
      in_valid = 1'b0;
      tick();
      chk("bp drained out_valid", 128'(out_valid), 128'(0));

      // flush with output and skid both occupied, plus a word offered that cycle
      @(negedge clock);
      out_ready = 1'b0;
      send(tag_word(4));
      tick();
      send(tag_word(5));
      tick();
      chk("flush pre in_ready", 128'(in_ready), 128'(0));
      @(negedge clock);
      flush     = 1'b1;
      in_valid  = 1'b1;
      instr_raw = tag_word(6);
      tick();
      chk("flush out_valid", 128'(out_valid), 128'(0));
      chk("flush in_ready", 128'(in_ready), 128'(1));
      @(negedge clock);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("flush nothing left", 128'(out_valid), 128'(0));

      // asynchronous reset while output and skid are full
      @(negedge clock);
      out_ready = 1'b0;
      send(tag_word(7));
      tick();
      send(tag_word(8));
      tick();
      chk("prereset rd", 128'(rd), 128'(7));
      @(negedge clock);
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("async reset out_valid", 128'(out_valid), 128'(0));
      chk("async reset in_ready", 128'(in_ready), 128'(1));
      chk("async reset payload", 128'(act), 128'(0));
      @(negedge clock);
      reset     = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("post reset out_valid", 128'(out_valid), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
